// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus initiator.
//   - Bus widths (ADDR_W, DATA_W, MASK_W)
//   - bus_size_e: access size encoding as carried on req_size
//   - init_state_e: initiator FSM states
//   - size_to_mask(): right-aligned byte-enable pattern for a size
//   - access_legal(): natural-alignment / size legality of a request
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } bus_size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } init_state_e;

    function automatic logic [MASK_W-1:0] size_to_mask(input bus_size_e size);
        logic [MASK_W-1:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001;
            SIZE_HALF: mask = 4'b0011;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Halves must be 2-byte aligned, words 4-byte aligned; size 3 is never legal.
    function automatic logic access_legal(input bus_size_e size, input logic [1:0] addr_lo);
        logic legal;
        case (size)
            SIZE_BYTE: legal = 1'b1;
            SIZE_HALF: legal = (addr_lo[0] == 1'b0);
            SIZE_WORD: legal = (addr_lo == 2'b00);
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/bus_read_extender.sv
// Combinational size/sign extension of a captured bus read word.
// Ports:
//   raw_data  in  32  data captured from data_bus (right-aligned)
//   size      in  2   access size (byte/half/word)
//   sign_en   in  1   replicate the top bit of the accessed field
//   ext_data  out 32  extended result; word accesses pass through unchanged
module bus_read_extender
    import bus_pkg::*;
(
    input  logic [DATA_W-1:0] raw_data,
    input  bus_size_e         size,
    input  logic              sign_en,
    output logic [DATA_W-1:0] ext_data
);

    logic fill_byte;
    logic fill_half;

    assign fill_byte = sign_en & raw_data[7];
    assign fill_half = sign_en & raw_data[15];

    // Each output bit is chosen by which lane it belongs to: the low byte always
    // passes, the second byte is filled only for byte accesses, the upper half
    // is filled for byte and half accesses.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            if (gi < 8) begin : g_lane0
                assign ext_data[gi] = raw_data[gi];
            end else if (gi < 16) begin : g_lane1
                assign ext_data[gi] = (size == SIZE_BYTE) ? fill_byte : raw_data[gi];
            end else begin : g_upper
                assign ext_data[gi] = (size == SIZE_BYTE) ? fill_byte :
                                      (size == SIZE_HALF) ? fill_half : raw_data[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/bus_initiator.sv
// Initiator end of the shared tri-state system bus. Accepts one access at a
// time over a valid/ready request channel, runs the addr/rd/wr/mask/fc
// handshake, and returns read data or write completion as a one-cycle pulse.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write, req_addr,
//   req_wdata, req_size,
//   req_signed                   request fields, registered at accept
//   resp_valid/resp_rdata/
//   resp_err                     one-cycle completion pulse with result
//   addr_bus, rd_bus, wr_bus,
//   data_mask_bus                bus outputs, decoded from state + request
//   data_bus                     bus data (inout), driven only in WRITE
//   fc_bus                       function complete; only a clean 1 counts
//
// Optional feature: define BUS_TIMEOUT_EN to abort an access with an error
// after TIMEOUT_CYCLES cycles without fc_bus. Without it, the initiator waits
// indefinitely.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] addr_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              rd_bus,
    output logic              wr_bus,
    output logic [MASK_W-1:0] data_mask_bus,
    input  logic              fc_bus
);

    init_state_e       state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    bus_size_e         size_reg;
    logic              signed_reg;
    logic              write_reg;
    logic              err_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [DATA_W-1:0] ext_data;

    logic accept;
    logic req_legal;
    logic bus_active;
    logic fc_done;
    logic timeout_hit;

    assign accept     = req_valid && (state_reg == ST_IDLE);
    assign req_legal  = access_legal(bus_size_e'(req_size), req_addr[1:0]);
    assign bus_active = (state_reg == ST_READ) || (state_reg == ST_WRITE);
    // An undriven (X/Z) fc means no responder claimed the address: not done.
    assign fc_done    = (fc_bus === 1'b1);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;

    // Counts wait cycles of the current access; held at zero outside READ/WRITE
    // so every access starts from a clean count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (bus_active && !fc_done) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign timeout_hit = bus_active && !fc_done && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES));
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_legal) begin
                        state_next = ST_RELEASE;
                    end else if (req_write) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ, ST_WRITE: begin
                if (fc_done || timeout_hit) begin
                    state_next = ST_RELEASE;
                end
            end
            // One mandatory idle bus cycle so the responder drops fc before
            // the next access can begin.
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg   <= '0;
            wdata_reg  <= '0;
            size_reg   <= SIZE_BYTE;
            signed_reg <= 1'b0;
            write_reg  <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            if (accept) begin
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
                size_reg   <= bus_size_e'(req_size);
                signed_reg <= req_signed;
                write_reg  <= req_write;
                err_reg    <= !req_legal;
                rdata_reg  <= '0;
            end
            // Read data is valid on the bus in the same cycle fc is seen.
            if ((state_reg == ST_READ) && fc_done) begin
                rdata_reg <= data_bus;
            end
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    bus_read_extender u_read_extender (
        .raw_data (rdata_reg),
        .size     (size_reg),
        .sign_en  (signed_reg),
        .ext_data (ext_data)
    );

    assign req_ready     = (state_reg == ST_IDLE);
    assign addr_bus      = bus_active ? addr_reg : '0;
    assign rd_bus        = (state_reg == ST_READ);
    assign wr_bus        = (state_reg == ST_WRITE);
    assign data_mask_bus = bus_active ? size_to_mask(size_reg) : '0;
    assign data_bus      = (state_reg == ST_WRITE) ? wdata_reg : {DATA_W{1'bz}};

    assign resp_valid = (state_reg == ST_RELEASE);
    assign resp_err   = (state_reg == ST_RELEASE) && err_reg;
    assign resp_rdata = ((state_reg == ST_RELEASE) && !err_reg && !write_reg) ? ext_data : '0;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed cases plus randomized
// accesses against an arithmetic reference model, with a responder that can
// answer combinationally or one cycle after the strobe. Addresses with
// top nibble 0xF are unmapped (fc and data left floating).
module tb_bus_initiator;

`ifdef BUS_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] addr_bus;
    wire  [31:0] data_bus;
    logic        rd_bus;
    logic        wr_bus;
    logic [3:0]  data_mask_bus;
    wire         fc_bus;

    // responder model
    logic        comb_mode = 1'b1;
    logic [31:0] rd_value = '0;
    logic        fc_reg = 1'b0;
    logic [31:0] hold_reg = '0;
    int          fc_hs = 0;
    logic        mapped;
    logic        fc_val;

    int errors = 0;
    int checks = 0;
    int txn_no = 0;

    bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .addr_bus      (addr_bus),
        .data_bus      (data_bus),
        .rd_bus        (rd_bus),
        .wr_bus        (wr_bus),
        .data_mask_bus (data_mask_bus),
        .fc_bus        (fc_bus)
    );

    always #5 clk = ~clk;

    assign mapped   = (addr_bus[31:28] != 4'hF);
    assign fc_val   = comb_mode ? (rd_bus | wr_bus) : fc_reg;
    assign fc_bus   = mapped ? fc_val : 1'bz;
    assign data_bus = (rd_bus && mapped) ? rd_value : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        fc_reg <= (rd_bus | wr_bus) && mapped;
        if (wr_bus && mapped && fc_bus === 1'b1) begin
            hold_reg <= data_bus;
            fc_hs    <= fc_hs + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference result {err, rdata} derived from the access rules.
    function automatic logic [32:0] model(input logic wr, input logic [31:0] addr,
                                         input logic [1:0] size, input logic sgn,
                                         input logic [31:0] rdval);
        logic        legal;
        logic [31:0] v;
        legal = (size == 0) || (size == 1 && addr % 2 == 0) || (size == 2 && addr % 4 == 0);
        if (!legal) return {1'b1, 32'h0};
        if (wr) return {1'b0, 32'h0};
        if (size == 0) begin
            v = rdval % 256;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = rdval % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdval;
        end
        return {1'b0, v};
    endfunction

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic sgn, input logic [31:0] rdval,
                           input logic comb);
        logic [32:0] exp;
        int          exp_lat;
        logic [3:0]  exp_mask;
        int          lat;
        int          strobes;
        bit          got;
        exp      = model(wr, addr, size, sgn, rdval);
        exp_mask = 4'((1 << (1 << size)) - 1);
        if (exp[32] && addr[31:28] != 4'hF) exp_lat = 1;
        else if (addr[31:28] == 4'hF) begin
            exp_lat = TMO + 2;
            exp     = {1'b1, 32'h0};
        end else exp_lat = comb ? 2 : 3;
        if (size == 3 || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0)) exp_lat = 1;

        @(negedge clk);
        rd_value   = rdval;
        comb_mode  = comb;
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; strobes = 0; got = 0;
        while (!got && lat < TMO + 20) begin
            @(negedge clk);
            lat++;
            if (rd_bus || wr_bus) begin
                strobes++;
                chk("dir", {30'd0, rd_bus, wr_bus}, wr ? 32'd1 : 32'd2);
                chk("mask", 32'(data_mask_bus), 32'(exp_mask));
                chk("addr_bus", addr_bus, addr);
                if (wr_bus) chk("wdata_bus", data_bus, wdata);
            end
            if (resp_valid) begin
                got = 1;
                chk("latency", lat, exp_lat);
                chk("err", 32'(resp_err), 32'(exp[32]));
                chk("rdata", resp_rdata, exp[31:0]);
                chk("ready_release", 32'(req_ready), 32'd0);
                chk("release_bus", {addr_bus[27:0], rd_bus, wr_bus, data_mask_bus[1:0]} |
                                   {30'd0, data_mask_bus[3:2]} | {addr_bus[31:28], 28'd0}, 32'd0);
            end
        end
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
        chk("strobe_cycles", strobes, exp_lat - 1);
        txn_no++;
        $display("txn %0d: %s addr=%h size=%0d sgn=%0b err=%0b rdata=%h lat=%0d",
                 txn_no, wr ? "WR" : "RD", addr, size, sgn, resp_err, resp_rdata, lat);
    endtask

    initial begin
        int hs0;
        int ready_seen;
        int rd_cnt;
        int pulses;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr", addr_bus, 32'd0);
        chk("rst_strobes", {26'd0, rd_bus, wr_bus, data_mask_bus}, 32'd0);
        rst = 1'b0;

        // directed
        run_txn(0, 32'h100, 0, 2, 0, 32'hDEADBEEF, 1);
        run_txn(0, 32'h101, 0, 0, 1, 32'h12345680, 1);
        run_txn(0, 32'h101, 0, 0, 0, 32'h12345680, 1);
        run_txn(0, 32'h102, 0, 1, 1, 32'h00008001, 0);
        run_txn(0, 32'h102, 0, 1, 0, 32'hABCD8001, 1);
        hs0 = fc_hs;
        run_txn(1, 32'h200, 32'h11, 2, 0, 0, 0);
        run_txn(1, 32'h200, 32'h22, 2, 0, 0, 0);
        chk("wr_handshakes", fc_hs - hs0, 32'd2);
        chk("responder_hold", hold_reg, 32'h22);
        run_txn(0, 32'h102, 0, 2, 0, 32'h5555_5555, 1);
        run_txn(1, 32'h100, 32'h33, 3, 0, 0, 1);
        run_txn(1, 32'h101, 32'h44, 1, 0, 0, 1);

        // randomized
        for (int i = 0; i < 40; i++) begin
            a = $urandom & 32'h0FFF_FFFF;
            run_txn(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        // unmapped read
`ifdef BUS_TIMEOUT_EN
        run_txn(0, 32'hF000_0000, 0, 2, 0, 32'h1234_5678, 1);
`else
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hF000_0000; req_size = 2'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ready_seen = 0; rd_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (req_ready) ready_seen++;
            if (rd_bus) rd_cnt++;
        end
        chk("hang_ready", ready_seen, 32'd0);
        chk("hang_rd", rd_cnt, 32'd1000);
        rst = 1'b1;
        #1 chk("hang_rst_rd", 32'(rd_bus), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("txn: unmapped read held for 1000 cycles, cleared by reset");
`endif

        // reset during a write wait
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hF000_0010;
        req_wdata = 32'hAA; req_size = 2'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("wr_wait", 32'(wr_bus), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_wr", 32'(wr_bus), 32'd0);
        chk("rst_mid_mask", 32'(data_mask_bus), 32'd0);
        chk("rst_mid_addr", addr_bus, 32'd0);
        chk("rst_mid_resp", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("rst_no_pulse", pulses, 32'd0);
        chk("rst_ready_after", 32'(req_ready), 32'd1);
        $display("txn: write aborted by reset");
        run_txn(0, 32'h300, 0, 2, 0, 32'hCAFE_F00D, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
